// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: access sizes, FSM states and
// the helper that turns an access size into its low-address alignment mask.
package dmem_responder_pkg;

    typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W, MEM_D} mem_size_e;

    typedef enum logic [1:0] {DM_IDLE, DM_WAIT, DM_RESP} dmem_state_e;

    localparam int unsigned XLEN = 64;

    // Address bits below the access size: any of them set means misaligned.
    function automatic logic [2:0] size_mask(mem_size_e size);
        logic [2:0] mask;
        mask = 3'b000;
        case (size)
            MEM_B:   mask = 3'b000;
            MEM_H:   mask = 3'b001;
            MEM_W:   mask = 3'b011;
            MEM_D:   mask = 3'b111;
            default: mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the core (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    mem_size_e   req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_responder_lane_aligner.sv
// Byte-lane steering for the responder: merges right-justified store data into
// the addressed bytes of an array word, and extracts/extends load data.
module dmem_responder_lane_aligner
    import dmem_responder_pkg::*;
(
    input  mem_size_e   i_size,
    input  logic [2:0]  i_offset,
    input  logic        i_unsigned,
    input  logic [63:0] i_wdata,
    input  logic [63:0] i_word,
    output logic [63:0] o_wword,
    output logic [63:0] o_rdata
);

    logic [5:0]  w_shift;
    logic [15:0] w_be_wide;
    logic [7:0]  w_be;
    logic [63:0] w_wdata_sh;
    logic [63:0] w_raw;

    assign w_shift    = {i_offset, 3'b000};
    // Computed wide so a misaligned offset cannot wrap enables into low lanes.
    assign w_be_wide  = ((16'd1 << (4'd1 << i_size)) - 16'd1) << i_offset;
    assign w_be       = w_be_wide[7:0];
    assign w_wdata_sh = i_wdata << w_shift;
    assign w_raw      = i_word >> w_shift;

    // Byte-enabled merge of shifted store data over the existing word.
    always_comb begin
        o_wword = i_word;
        for (int b = 0; b < 8; b++) begin
            if (w_be[b]) begin
                o_wword[b*8 +: 8] = w_wdata_sh[b*8 +: 8];
            end
        end
    end

    // Load extraction with sign or zero extension by size.
    always_comb begin
        o_rdata = w_raw;
        unique case (i_size)
            MEM_B: o_rdata = {{56{w_raw[7]  & ~i_unsigned}}, w_raw[7:0]};
            MEM_H: o_rdata = {{48{w_raw[15] & ~i_unsigned}}, w_raw[15:0]};
            MEM_W: o_rdata = {{32{w_raw[31] & ~i_unsigned}}, w_raw[31:0]};
            MEM_D: o_rdata = w_raw;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the core load/store port: one request at a time, fixed
// wait states, byte-lane steering and load extension over a 64-bit array.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned access -> rsp_err).
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);

    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);

    dmem_state_e r_state;
    logic [CNT_W-1:0] r_cnt;
    logic        r_we;
    mem_size_e   r_size;
    logic        r_unsigned;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic        r_rsp_valid;
    logic [63:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [63:0] r_mem [DEPTH];

    logic        w_accept;
    logic        w_commit;
    logic        w_cur_we;
    mem_size_e   w_cur_size;
    logic        w_cur_unsigned;
    logic [63:0] w_cur_addr;
    logic [63:0] w_cur_wdata;
    logic [2:0]  w_mask;
    logic [2:0]  w_offset;
    logic        w_oor;
    logic        w_err;
    logic [IDX_W-1:0] w_idx;
    logic [63:0] w_word;
    logic [63:0] w_wword;
    logic [63:0] w_rdata;

    assign w_accept = bus.req_valid && (r_state == DM_IDLE);

    // With zero wait states the commit edge is the accept edge, so the live
    // request fields are used instead of the (not yet loaded) latched copy.
    assign w_cur_we       = (r_state == DM_IDLE) ? bus.req_we       : r_we;
    assign w_cur_size     = (r_state == DM_IDLE) ? bus.req_size     : r_size;
    assign w_cur_unsigned = (r_state == DM_IDLE) ? bus.req_unsigned : r_unsigned;
    assign w_cur_addr     = (r_state == DM_IDLE) ? bus.req_addr     : r_addr;
    assign w_cur_wdata    = (r_state == DM_IDLE) ? bus.req_wdata    : r_wdata;

    assign w_commit = reset &&
                      ((ZERO_WAIT && w_accept) ||
                       ((r_state == DM_WAIT) && (r_cnt == CNT_W'(WAIT_CYCLES))));

    assign w_mask = size_mask(w_cur_size);
    // Full word index compared, not just the array index bits, so high
    // addresses cannot alias onto the array.
    assign w_oor  = (w_cur_addr[63:3] >= 61'(DEPTH));
    assign w_idx  = w_cur_addr[3 +: IDX_W];
    assign w_word = r_mem[w_idx];

`ifdef MISALIGN_TRAP_EN
    assign w_offset = w_cur_addr[2:0];
    assign w_err    = w_oor || (|(w_cur_addr[2:0] & w_mask));
`else
    assign w_offset = w_cur_addr[2:0] & ~w_mask;
    assign w_err    = w_oor;
`endif

    dmem_responder_lane_aligner u_lane_aligner (
        .i_size     (w_cur_size),
        .i_offset   (w_offset),
        .i_unsigned (w_cur_unsigned),
        .i_wdata    (w_cur_wdata),
        .i_word     (w_word),
        .o_wword    (w_wword),
        .o_rdata    (w_rdata)
    );

    assign bus.req_ready = (r_state == DM_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

    // Array write on the edge entering RESP; faulting stores never land.
    always_ff @(posedge clk) begin
        if (w_commit && w_cur_we && !w_err) begin
            r_mem[w_idx] <= w_wword;
        end
    end

    // Request/response FSM with registered response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= DM_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_size      <= MEM_B;
            r_unsigned  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                DM_IDLE: begin
                    if (w_accept) begin
                        r_we       <= bus.req_we;
                        r_size     <= bus.req_size;
                        r_unsigned <= bus.req_unsigned;
                        r_addr     <= bus.req_addr;
                        r_wdata    <= bus.req_wdata;
                        r_cnt      <= '0;
                        if (ZERO_WAIT) begin
                            r_state     <= DM_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= w_err;
                            r_rsp_rdata <= (w_err || w_cur_we) ? 64'd0 : w_rdata;
                        end else begin
                            r_state <= DM_WAIT;
                        end
                    end
                end
                DM_WAIT: begin
                    if (r_cnt == CNT_W'(WAIT_CYCLES)) begin
                        r_state     <= DM_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= (w_err || w_cur_we) ? 64'd0 : w_rdata;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DM_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state     <= DM_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= DM_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
